// File: rtl/line_buffer_pkg.sv
// Shared defaults and counter-width helper for the line buffer, window and Sobel stages.
package line_buffer_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned IMG_W_DEF  = 640;
    localparam int unsigned IMG_H_DEF  = 480;
    localparam int unsigned LINES_DEF  = 3;

    // Counter width for a range of n positions; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_ram.sv
// One image row of pixels: synchronous write, asynchronous read, so a read and a
// write to the same address in one cycle return the old contents.
module line_ram
    import line_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = IMG_W_DEF
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [cnt_w(DEPTH)-1:0]  addr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_c_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_c_o = mem_q[addr_i];

endmodule

// File: rtl/multi_line_buffer.sv
// Streaming line buffer: emits one vertically aligned column of LINES pixels per
// accepted raster-order pixel, with its coordinates and an end-of-frame pulse.
module multi_line_buffer
    import line_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned LINES  = LINES_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we_i,
    input  logic                       sof_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic [LINES*DATA_W-1:0]    data_o,
    output logic                       valid_o,
    output logic [cnt_w(IMG_W)-1:0]    col_o,
    output logic [cnt_w(IMG_H)-1:0]    row_o,
    output logic                       done_o
);

    localparam int unsigned COL_W = cnt_w(IMG_W);
    localparam int unsigned ROW_W = cnt_w(IMG_H);
    localparam int unsigned OUT_W = LINES * DATA_W;

    logic [COL_W-1:0] col_q, col_d, cur_col, col_o_q;
    logic [ROW_W-1:0] row_q, row_d, cur_row, row_o_q;
    logic             last_col, last_row;
    logic             valid_d, valid_q, done_d, done_q;
    logic [OUT_W-1:0] data_q;

    logic [LINES-1:0][DATA_W-1:0] tap;

    // Tap k is the pixel k rows above; each RAM shifts its old word into the next.
    assign tap[0] = data_i;

    for (genvar k = 1; k < LINES; k++) begin : g_ram
        line_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W)
        ) u_line_ram (
            .clk       (clk),
            .we_i      (we_i),
            .addr_i    (cur_col),
            .wdata_i   (tap[k-1]),
            .rdata_c_o (tap[k])
        );
    end

    // Position of the pixel being accepted, and the counter state after it.
    always_comb begin
        cur_col  = sof_i ? '0 : col_q;
        cur_row  = sof_i ? '0 : row_q;
        last_col = (cur_col == COL_W'(IMG_W - 1));
        last_row = (cur_row == ROW_W'(IMG_H - 1));
        col_d    = col_q;
        row_d    = row_q;
        if (we_i) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
        end
        valid_d = we_i && (cur_row >= ROW_W'(LINES - 1));
        done_d  = valid_d && last_col && last_row;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            col_o_q <= '0;
            row_o_q <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            if (we_i) begin
                data_q  <= OUT_W'(tap);
                col_o_q <= cur_col;
                row_o_q <= cur_row;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign col_o   = col_o_q;
    assign row_o   = row_o_q;

endmodule

// File: tb/tb_multi_line_buffer.sv
// Directed bench for multi_line_buffer on a 4x4 image with 3-row columns.
module tb_multi_line_buffer;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic        sof_i;
    logic [7:0]  data_i;
    logic [23:0] data_o;
    logic        valid_o;
    logic [1:0]  col_o;
    logic [1:0]  row_o;
    logic        done_o;

    int n_cmp;
    int n_fail;

    multi_line_buffer #(
        .DATA_W (8),
        .IMG_W  (4),
        .IMG_H  (4),
        .LINES  (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_i),
        .sof_i   (sof_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .col_o   (col_o),
        .row_o   (row_o),
        .done_o  (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Column for pixel p of a frame whose pixels are base+index: {top, middle, newest}.
    function automatic logic [23:0] exp_col(input int base, input int p);
        logic [7:0] top, mid, bot;
        top = 8'(base + p - 8);
        mid = 8'(base + p - 4);
        bot = 8'(base + p);
        return {top, mid, bot};
    endfunction

    task automatic push(input logic [7:0] v, input logic s);
        @(negedge clk);
        we_i = 1'b1; sof_i = s; data_i = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        we_i = 1'b0; sof_i = 1'b0; data_i = 8'hA5;
        @(posedge clk);
        #1;
    endtask

    // Drives one full 4x4 frame (optionally with gap bubbles after each pixel) and checks every output.
    task automatic run_frame(input string tag, input int base, input bit sof0, input int gap);
        int dones;
        dones = 0;
        for (int p = 0; p < 16; p++) begin
            int r, c;
            bit ev, ed;
            r  = p / 4;
            c  = p % 4;
            ev = (r >= 2);
            ed = (p == 15);
            push(8'(base + p), sof0 && (p == 0));
            n_cmp++;
            if (valid_o !== ev) begin n_fail++; $display("FAIL %s valid p=%0d got %b exp %b", tag, p, valid_o, ev); end
            n_cmp++;
            if (done_o !== ed) begin n_fail++; $display("FAIL %s done p=%0d got %b exp %b", tag, p, done_o, ed); end
            n_cmp++;
            if (col_o !== 2'(c)) begin n_fail++; $display("FAIL %s col p=%0d got %0d exp %0d", tag, p, col_o, c); end
            n_cmp++;
            if (row_o !== 2'(r)) begin n_fail++; $display("FAIL %s row p=%0d got %0d exp %0d", tag, p, row_o, r); end
            if (ev) begin
                n_cmp++;
                if (data_o !== exp_col(base, p)) begin
                    n_fail++; $display("FAIL %s data p=%0d got %h exp %h", tag, p, data_o, exp_col(base, p));
                end
            end
            if (done_o === 1'b1) dones++;
            for (int g = 0; g < gap; g++) begin
                idle();
                n_cmp++;
                if (valid_o !== 1'b0 || done_o !== 1'b0) begin
                    n_fail++; $display("FAIL %s bubble flags p=%0d got v=%b d=%b exp 0/0", tag, p, valid_o, done_o);
                end
                n_cmp++;
                if (col_o !== 2'(c) || row_o !== 2'(r)) begin
                    n_fail++; $display("FAIL %s bubble pos p=%0d got (%0d,%0d) exp (%0d,%0d)", tag, p, row_o, col_o, r, c);
                end
                if (ev) begin
                    n_cmp++;
                    if (data_o !== exp_col(base, p)) begin
                        n_fail++; $display("FAIL %s bubble data p=%0d got %h exp %h", tag, p, data_o, exp_col(base, p));
                    end
                end
            end
        end
        n_cmp++;
        if (dones != 1) begin n_fail++; $display("FAIL %s done count got %0d exp 1", tag, dones); end
    endtask

    task automatic check_zero(input string tag);
        n_cmp++;
        if (data_o !== 24'h0 || valid_o !== 1'b0 || done_o !== 1'b0 || col_o !== 2'd0 || row_o !== 2'd0) begin
            n_fail++;
            $display("FAIL %s got data=%h v=%b d=%b col=%0d row=%0d exp all 0", tag, data_o, valid_o, done_o, col_o, row_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; we_i = 1'b0; sof_i = 1'b0; data_i = 8'h00;
        #1;
        check_zero("reset_t0");
        @(posedge clk); #1;
        check_zero("reset_edge1");
        @(posedge clk); #1;
        check_zero("reset_edge2");
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_stream();
        run_frame("stream", 0, 1'b1, 0);
        idle();
        n_cmp++;
        if (valid_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++; $display("FAIL stream_after flags got v=%b d=%b exp 0/0", valid_o, done_o);
        end
    endtask

    task automatic test_bubbles();
        run_frame("bubbles", 0, 1'b1, 3);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_f1", 0, 1'b1, 0);
        run_frame("b2b_f2", 100, 1'b0, 0);
        idle();
    endtask

    task automatic test_sof_resync();
        for (int p = 0; p < 6; p++) begin
            push(8'(p), p == 0);
            n_cmp++;
            if (valid_o !== 1'b0 || done_o !== 1'b0) begin
                n_fail++; $display("FAIL resync_partial p=%0d got v=%b d=%b exp 0/0", p, valid_o, done_o);
            end
        end
        run_frame("resync", 0, 1'b1, 0);
        idle();
    endtask

    task automatic test_mid_reset();
        for (int p = 0; p < 11; p++) begin
            push(8'(p + 50), p == 0);
            n_cmp++;
            if (valid_o !== (p >= 8)) begin
                n_fail++; $display("FAIL prereset valid p=%0d got %b exp %b", p, valid_o, (p >= 8));
            end
        end
        @(negedge clk);
        we_i = 1'b0; sof_i = 1'b0;
        rst = 1'b0;
        #1;
        check_zero("midreset_async");
        @(posedge clk); #1;
        check_zero("midreset_held");
        @(negedge clk);
        rst = 1'b1;
        run_frame("post_reset", 0, 1'b0, 0);
        idle();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_stream();
        test_bubbles();
        test_back_to_back();
        test_sof_resync();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
